// File: rtl/music_box_pkg.sv
// music_box_pkg: envelope state encoding and saturating amplitude arithmetic
package music_box_pkg;
  localparam int ENV_STATE_W = 3;
  typedef enum logic [ENV_STATE_W-1:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } env_state_t;
  function automatic int satAdd(int a, int step, int hi);
    return (a + step > hi) ? hi : a + step;
  endfunction
  function automatic int satSub(int a, int step, int lo);
    return (a - step < lo) ? lo : a - step;
  endfunction
endpackage

// File: rtl/envelope_channel.sv
// envelope_channel: one key's synchroniser, press detector and ADSR amplitude FSM
module envelope_channel
  import music_box_pkg::*;
#(
  parameter int AMP_W        = 8,
  parameter int PEAK_LVL     = 255,
  parameter int SUSTAIN_LVL  = 200,
  parameter int ATTACK_STEP  = 64,
  parameter int DECAY_STEP   = 3,
  parameter int RELEASE_STEP = 2
) (
  input  logic             CLK_1Khz,
  input  logic             reset_n,
  input  logic             play_enable,
  input  logic             key_n,
  output logic [AMP_W-1:0] envelope_out,
  output env_state_t       env_state,
  output logic             note_on,
  output logic             active
);
  localparam logic [AMP_W-1:0] peakLvl = AMP_W'(PEAK_LVL);
  localparam logic [AMP_W-1:0] sustainLvl = AMP_W'(SUSTAIN_LVL);
  logic syncA, syncB, prev, press, nextNote;
  logic [AMP_W-1:0] ampUp, ampDecay, ampRel, nextAmp;
  env_state_t nextState;
  assign ampUp = AMP_W'(satAdd(int'(envelope_out), ATTACK_STEP, PEAK_LVL));
  assign ampDecay = AMP_W'(satSub(int'(envelope_out), DECAY_STEP, SUSTAIN_LVL));
  assign ampRel = AMP_W'(satSub(int'(envelope_out), RELEASE_STEP, 0));
  assign press = !syncB && prev;
  assign active = env_state != IDLE;
  // A press edge retriggers from the current amplitude rather than from zero
  always_comb begin
    nextState = env_state;
    nextAmp = envelope_out;
    nextNote = 1'b0;
    if (!play_enable) begin
      nextState = IDLE;
      nextAmp = '0;
    end else if (press) begin
      nextState = ATTACK;
      nextAmp = ampUp;
      nextNote = 1'b1;
    end else if (syncB && env_state inside {ATTACK, DECAY, SUSTAIN}) begin
      nextState = RELEASE;
      nextAmp = ampRel;
    end else begin
      case (env_state)
        ATTACK: begin
          nextAmp = ampUp;
          nextState = (ampUp == peakLvl) ? DECAY : ATTACK;
        end
        DECAY: begin
          nextAmp = ampDecay;
          nextState = (ampDecay == sustainLvl) ? SUSTAIN : DECAY;
        end
        RELEASE: begin
          nextAmp = ampRel;
          nextState = (ampRel == '0) ? IDLE : RELEASE;
        end
        IDLE: nextAmp = '0;
        default: nextState = env_state;
      endcase
    end
  end
  // prev forced high while disabled so a held key re-arms as a fresh press
  always_ff @(posedge CLK_1Khz) begin
    if (!reset_n) begin
      syncA <= 1'b1;
      syncB <= 1'b1;
      prev <= 1'b1;
      env_state <= IDLE;
      envelope_out <= '0;
      note_on <= 1'b0;
    end else begin
      syncA <= key_n;
      syncB <= syncA;
      prev <= play_enable ? syncB : 1'b1;
      env_state <= nextState;
      envelope_out <= nextAmp;
      note_on <= nextNote;
    end
  end
endmodule

// File: rtl/music_key_envelope_bank.sv
// music_key_envelope_bank: bank of independent per-key ADSR envelope channels
module music_key_envelope_bank
  import music_box_pkg::*;
#(
  parameter int NUM_KEYS     = 6,
  parameter int AMP_W        = 8,
  parameter int PEAK_LVL     = 255,
  parameter int SUSTAIN_LVL  = 200,
  parameter int ATTACK_STEP  = 64,
  parameter int DECAY_STEP   = 3,
  parameter int RELEASE_STEP = 2
) (
  input  logic                            CLK_1Khz,
  input  logic                            reset_n,
  input  logic                            play_enable,
  input  logic [NUM_KEYS-1:0]             key_n,
  output logic [NUM_KEYS-1:0][AMP_W-1:0]  envelope_out,
  output env_state_t [NUM_KEYS-1:0]       env_state,
  output logic [NUM_KEYS-1:0]             note_on,
  output logic [NUM_KEYS-1:0]             active_mask
);
  if (NUM_KEYS < 1 || NUM_KEYS > 16) begin : badNumKeys
    $error("NUM_KEYS must be in 1..16");
  end
  if (PEAK_LVL > 2 ** AMP_W - 1 || SUSTAIN_LVL > PEAK_LVL) begin : badLevels
    $error("level parameters out of range");
  end
  if (ATTACK_STEP < 1 || DECAY_STEP < 1 || RELEASE_STEP < 1) begin : badSteps
    $error("step parameters must be at least 1");
  end
  for (genvar g = 0; g < NUM_KEYS; g++) begin : chan
    envelope_channel #(
      .AMP_W(AMP_W),
      .PEAK_LVL(PEAK_LVL),
      .SUSTAIN_LVL(SUSTAIN_LVL),
      .ATTACK_STEP(ATTACK_STEP),
      .DECAY_STEP(DECAY_STEP),
      .RELEASE_STEP(RELEASE_STEP)
    ) u_chan (
      .CLK_1Khz(CLK_1Khz),
      .reset_n(reset_n),
      .play_enable(play_enable),
      .key_n(key_n[g]),
      .envelope_out(envelope_out[g]),
      .env_state(env_state[g]),
      .note_on(note_on[g]),
      .active(active_mask[g])
    );
  end
endmodule

// File: doc/music_key_envelope_bank.md
# music_key_envelope_bank

Parametrised bank of per-key amplitude envelope generators for the music-box keypad, clocked at 1 kHz. Each channel runs a five-state attack/decay/sustain/release machine driven by a synchronised, active-low key input. The bank outputs an unsigned amplitude per channel that the 32 kHz signal generators consume as their amplitude input. A play-enable input, derived from the music-box state controller, silences and re-arms all channels.

## Interface
Parameters:
- NUM_KEYS, 6: number of key channels (1..16)
- AMP_W, 8: amplitude width in bits
- PEAK_LVL, 255: attack target; must be ≤ 2^AMP_W-1
- SUSTAIN_LVL, 200: decay floor and hold level; must be ≤ PEAK_LVL
- ATTACK_STEP, 64: increment per cycle in ATTACK; must be ≥1
- DECAY_STEP, 3: decrement per cycle in DECAY; must be ≥1
- RELEASE_STEP, 2: decrement per cycle in RELEASE; must be ≥1

Ports:
- CLK_1Khz, input, 1: envelope clock
- reset_n, input, 1: reset, synchronous, active-low
- play_enable, input, 1: 1 = keys may sound; 0 = force silence
- key_n, input, NUM_KEYS: raw key levels, 0 = pressed, asynchronous
- envelope_out, output, NUM_KEYS×AMP_W (packed [NUM_KEYS-1:0][AMP_W-1:0]): per-channel amplitude
- env_state, output, NUM_KEYS×3: per-channel env_state_t
- note_on, output, NUM_KEYS: one-cycle pulse per detected press
- active_mask, output, NUM_KEYS: 1 where the channel state ≠ IDLE

## Operation
- Synchroniser: two flops per key, reset to 1. `prev` holds the last synchronised value (sync2), also reset to 1.
- Press edge: sync2 = 0 and prev = 1.
- Release level: sync2 = 1.
- States are IDLE, ATTACK, DECAY, SUSTAIN and RELEASE. All outputs reset to 0 and all states reset to IDLE.
- Saturating arithmetic is computed in AMP_W+1 bits.
  - Add clamps at PEAK_LVL.
  - Decay subtract clamps at SUSTAIN_LVL.
  - Release subtract clamps at 0.
- Transitions are evaluated each enabled cycle in this priority order:
  1. Press edge, from any state: go to ATTACK, amp ← sat_add(amp, ATTACK_STEP), note_on = 1 next cycle. This is a retrigger: amp continues from its current value and is not zeroed.
  2. ATTACK with release level: go to RELEASE, amp ← sat_sub0(amp, RELEASE_STEP).
  3. ATTACK: amp ← sat_add. If the result equals PEAK_LVL, go to DECAY.
  4. DECAY with release level: go to RELEASE with release subtract.
  5. DECAY: amp ← sat_subS(amp, DECAY_STEP). If the result equals SUSTAIN_LVL, go to SUSTAIN.
  6. SUSTAIN: hold amp. On release level, go to RELEASE with release subtract.
  7. RELEASE: amp ← sat_sub0. If the result is 0, go to IDLE.
  8. IDLE: amp stays 0.
- If SUSTAIN_LVL = PEAK_LVL, the channel goes directly ATTACK→DECAY→SUSTAIN with no decrement.
- When play_enable = 0 (sampled), in the same cycle:
  - Every channel goes to IDLE with amp 0 and note_on 0.
  - prev is forced to 1.
  - The synchronisers keep running.
  - Consequence: a key held while play_enable rises produces a fresh press edge.
- Channels are fully independent. Simultaneous presses on several keys each retrigger in the same cycle.

## Timing
- All outputs are registered.
- Press latency: key_n falls before edge e. sync2 = 0 after edge e+1. The press is detected at edge e+2, so envelope_out = ATTACK_STEP (from 0) and note_on = 1 after edge e+2.
- note_on is high for exactly one cycle per press edge.
- Release latency is the same: two synchroniser edges, then the state changes at the next edge.
- With default parameters, starting from IDLE:
  - Attack: 64, 128, 192, 255. The state is DECAY after the 4th edge.
  - Decay: 252, 249, …, 201, 200. The state is SUSTAIN after 19 edges.
  - Release from 200: 100 edges to 0, then IDLE.
- Reset has priority over play_enable and over key activity. If asserted mid-envelope, all outputs are 0 after the next edge and the synchronisers are reloaded with 1.

## Structure
- Package music_box_pkg holds:
  - env_state_t, a 3-bit enum: IDLE = 0, ATTACK = 1, DECAY = 2, SUSTAIN = 3, RELEASE = 4.
  - ENV_STATE_W = 3.
  - Saturating add/subtract functions.
- Sub-module envelope_channel contains one synchroniser, edge detector, FSM and amplitude register, and takes the same parameters.
- The top module generates NUM_KEYS instances and packs their outputs.
- Elaboration-time assertions check the parameter constraints listed under Interface.

## Test plan
- **Reset:** reset_n = 0 for 3 cycles with all keys pressed → all outputs 0, all states IDLE. After release of reset, with play_enable = 1 and keys still held, note_on pulses once per key 2 cycles later.
- **Full envelope, key 0:** hold 30 cycles, then release → amp 64/128/192/255, decay to 200 in 19 cycles, hold 200, then drop by 2 per cycle to 0 in 100 cycles, then IDLE and active_mask[0] = 0.
- **Early release:** release key 1 after the 2nd ATTACK cycle (amp 128) → RELEASE with 126, 124, …, 0. The amplitude never reaches 255.
- **Retrigger:** press key 2 again while amp = 150 in RELEASE → note_on pulse, amp 214, then 255 and DECAY.
- **Enable gating:** drop play_enable mid-SUSTAIN on keys 3 and 4 → both 0 and IDLE in 1 cycle. Raise play_enable with keys held → new press edge, amp 64.
- **Parameter sweep:** NUM_KEYS = 1, AMP_W = 4, PEAK_LVL = 15, SUSTAIN_LVL = 15, ATTACK_STEP = 7 → amp 7, 14, 15, then DECAY→SUSTAIN at 15. Release with RELEASE_STEP = 2 steps down to 0 without underflow.
